bf_program_sender: RTL and testbench

//  Board-side UART transmitter that streams a stored Brainfuck program into the

---
 rtl/bf_program_sender_if.sv | 30 +++
 rtl/bf_program_sender.sv | 231 +++++++++++++++++++++++
 tb/tb_bf_program_sender.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bf_program_sender_if.sv
// Program-sender bus: buffer write port, transfer request and the UART/loading outputs.
// Latency: none (signal bundle only).
// Backpressure: none; requests are simply ignored by the sender while busy is high.
//
// Ports (via modports):
//   master : drives wr_en/wr_addr/wr_data/prog_len/start, observes busy/loading/done/tx
//   slave  : the sender itself; the mirror image of master
interface bf_program_sender_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_data;
    logic [ADDR_WIDTH:0]   prog_len;
    logic                  start;
    logic                  busy;
    logic                  loading;
    logic                  done;
    logic                  tx;

    modport master (
        output wr_en, wr_addr, wr_data, prog_len, start,
        input  busy, loading, done, tx
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, prog_len, start,
        output busy, loading, done, tx
    );
endinterface

// File: rtl/bf_program_sender.sv
// Streams a stored program buffer as 8N1 UART frames on tx while holding loading high.
// Latency: loading one cycle after start; first start bit SETUP_CYCLES later; done at end of last frame.
// Backpressure: none; start and buffer writes are dropped while busy is high.
//
// Ports:
//   clk    main clock
//   reset  synchronous active-high reset (aborts a transfer, buffer contents kept)
//   bus    bf_program_sender_if.slave: wr_en/wr_addr/wr_data buffer write, prog_len/start
//          request, busy/loading/done status, tx UART line (idle high)
module bf_program_sender #(
    parameter int ADDR_WIDTH   = 9,
    parameter int CLK_PER_BIT  = 104,
    parameter int SETUP_CYCLES = 16,
    parameter int GAP_CYCLES   = 0
) (
    input  logic                clk,
    input  logic                reset,
    bf_program_sender_if.slave  bus
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int BAUD_W = $clog2(CLK_PER_BIT);
    localparam int PH_MAX = (SETUP_CYCLES > GAP_CYCLES)
                          ? ((SETUP_CYCLES > 2) ? SETUP_CYCLES : 2)
                          : ((GAP_CYCLES > 2) ? GAP_CYCLES : 2);
    localparam int PH_W   = $clog2(PH_MAX);

    localparam logic [BAUD_W-1:0]   BAUD_LAST  = BAUD_W'(CLK_PER_BIT - 1);
    localparam logic [PH_W-1:0]     SETUP_LAST = PH_W'(SETUP_CYCLES - 1);
    localparam logic [PH_W-1:0]     GAP_LAST   = PH_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ADDR_WIDTH:0] LEN_MAX    = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP,
        S_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic [2:0]            bit_q, bit_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [7:0]            shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  loading_q, loading_d;
    logic                  done_q, done_d;
    logic                  frame_end;

    // ------------------------------------------------------------------
    // Program buffer: single port, registered read. While idle the port
    // follows the write address; during a transfer it follows the byte
    // index, so the next byte is fetched long before its frame begins.
    // ------------------------------------------------------------------
    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [7:0]            ram_rd_dat;

    assign ram_we   = bus.wr_en & ~busy_q;
    assign ram_addr = busy_q ? idx_q[ADDR_WIDTH-1:0] : bus.wr_addr;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= bus.wr_data;
        end
        ram_rd_dat <= mem[ram_addr];
    end

    // Oversized requests clamp to a full buffer.
    logic [ADDR_WIDTH:0] len_sat;
    assign len_sat = (bus.prog_len > LEN_MAX) ? LEN_MAX : bus.prog_len;

    // ------------------------------------------------------------------
    // Sequencer. Every output is registered: *_d holds the value for the
    // state being entered, so tx changes exactly on frame/bit boundaries.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        ph_d      = ph_q;
        bit_d     = bit_q;
        idx_d     = idx_q;
        len_d     = len_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        loading_d = loading_q;
        done_d    = 1'b0;
        frame_end = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (bus.start) begin
                    len_d     = len_sat;
                    idx_d     = '0;
                    ph_d      = '0;
                    busy_d    = 1'b1;
                    loading_d = 1'b1;
                    state_d   = (len_sat == '0) ? S_FINISH : S_SETUP;
                end
            end
            S_SETUP: begin
                if (ph_q == SETUP_LAST) begin
                    state_d = S_START;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_START: begin
                if (baud_q == BAUD_LAST) begin
                    // Byte is captured here, so the index can move on and the
                    // RAM has the whole frame to fetch the next one.
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    shift_d = ram_rd_dat;
                    tx_d    = ram_rd_dat[0];
                    idx_d   = idx_q + (ADDR_WIDTH + 1)'(1);
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {shift_q[0], shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                        ph_d    = '0;
                    end else begin
                        frame_end = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_GAP: begin
                if (ph_q == GAP_LAST) begin
                    frame_end = 1'b1;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_FINISH: begin
                // Only reached for zero-length requests: loading stays up for
                // this single cycle, done follows.
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                loading_d = 1'b0;
                done_d    = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // idx_q already counts the byte just sent. The closing edge of the
        // last frame is also the finish edge, so done lands exactly on the
        // frame boundary instead of one cycle later.
        if (frame_end) begin
            if (idx_q == len_q) begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                loading_d = 1'b0;
                done_d    = 1'b1;
                tx_d      = 1'b1;
            end else begin
                state_d = S_START;
                tx_d    = 1'b0;
                baud_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            ph_q      <= '0;
            bit_q     <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            loading_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            ph_q      <= ph_d;
            bit_q     <= bit_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            loading_q <= loading_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.loading = loading_q;
    assign bus.done    = done_q;
    assign bus.tx      = tx_q;

endmodule

// File: tb/tb_bf_program_sender.sv
// Bench for bf_program_sender: two instances (no gap / 3-cycle gap) checked every cycle
// against a closed-form timing model, plus a UART decoder and literal timing expectations.
module tb_bf_program_sender;

    localparam int AW_A = 9;
    localparam int AW_B = 2;
    localparam int C    = 4;
    localparam int S    = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       wr_en    = '0;
    logic [1:0][8:0]  wr_addr  = '0;
    logic [1:0][7:0]  wr_data  = '0;
    logic [1:0][9:0]  prog_len = '0;
    logic [1:0]       start    = '0;
    logic [1:0][3:0]  dut_out;   // {tx, loading, busy, done}

    bf_program_sender_if #(.ADDR_WIDTH(AW_A)) bus_a ();
    bf_program_sender_if #(.ADDR_WIDTH(AW_B)) bus_b ();

    assign bus_a.wr_en    = wr_en[0];
    assign bus_a.wr_addr  = wr_addr[0];
    assign bus_a.wr_data  = wr_data[0];
    assign bus_a.prog_len = prog_len[0];
    assign bus_a.start    = start[0];
    assign bus_b.wr_en    = wr_en[1];
    assign bus_b.wr_addr  = wr_addr[1][AW_B-1:0];
    assign bus_b.wr_data  = wr_data[1];
    assign bus_b.prog_len = prog_len[1][AW_B:0];
    assign bus_b.start    = start[1];
    assign dut_out[0] = {bus_a.tx, bus_a.loading, bus_a.busy, bus_a.done};
    assign dut_out[1] = {bus_b.tx, bus_b.loading, bus_b.busy, bus_b.done};

    bf_program_sender #(.ADDR_WIDTH(AW_A), .CLK_PER_BIT(C), .SETUP_CYCLES(S), .GAP_CYCLES(0))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    bf_program_sender #(.ADDR_WIDTH(AW_B), .CLK_PER_BIT(C), .SETUP_CYCLES(S), .GAP_CYCLES(3))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // ---------------- behavioural model ----------------
    logic [7:0] mdl_mem  [2][512];
    logic [7:0] mdl_snap [2][512];
    bit         mdl_active [2];
    int         mdl_t0 [2];
    int         mdl_len [2];

    function automatic int p_gap(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic int p_depth(input int i);
        return (i == 0) ? (1 << AW_A) : (1 << AW_B);
    endfunction

    // Expected {tx, loading, busy, done} d cycles after the accepting edge.
    function automatic logic [3:0] expect_out(input int i, input int d);
        int L, F, E, p, k, r;
        logic [7:0] b;
        if (!mdl_active[i]) return 4'b1000;
        L = mdl_len[i];
        F = 10 * C + p_gap(i);
        E = (L == 0) ? 2 : 1 + S + L * F;
        if (d < 1 || d > E) return 4'b1000;
        if (d == E) return 4'b1001;
        if (L == 0 || d < 1 + S) return 4'b1110;
        p = d - 1 - S;
        k = p / F;
        r = p % F;
        if (r < C) return 4'b0110;
        if (r < 9 * C) begin
            b = mdl_snap[i][k];
            return {b[(r - C) / C], 3'b110};
        end
        return 4'b1110;
    endfunction

    always @(posedge clk) begin
        logic [3:0] prev;
        int len;
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                mdl_active[i] = 1'b0;
            end else begin
                prev = expect_out(i, cyc - 1 - mdl_t0[i]);
                if (!prev[1]) begin
                    if (wr_en[i]) mdl_mem[i][int'(wr_addr[i]) % p_depth(i)] = wr_data[i];
                    if (start[i]) begin
                        len = int'(prog_len[i]);
                        if (len > p_depth(i)) len = p_depth(i);
                        for (int a = 0; a < 512; a++) mdl_snap[i][a] = mdl_mem[i][a];
                        mdl_len[i]    = len;
                        mdl_t0[i]     = cyc - 1;
                        mdl_active[i] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- event log + UART decoder ----------------
    // kinds: 0 frame start, 1 loading rise, 2 loading fall, 3 done
    int         ev_cyc [2][4][2048];
    int         ev_n   [2][4];
    logic [7:0] dec_buf [2][2048];
    int         dec_n [2];
    logic       prev_ld [2];
    bit         rx_on [2];
    int         rx_t0 [2];
    logic [7:0] rx_sh [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            dec_n[i] = 0; prev_ld[i] = 1'b0; rx_on[i] = 1'b0; rx_t0[i] = 0; rx_sh[i] = '0;
            mdl_active[i] = 1'b0; mdl_t0[i] = 0; mdl_len[i] = 0;
            for (int k = 0; k < 4; k++) ev_n[i][k] = 0;
        end
    end

    function automatic void push_ev(input int i, input int k, input int c);
        ev_cyc[i][k][ev_n[i][k]] = c;
        if (ev_n[i][k] < 2047) ev_n[i][k] = ev_n[i][k] + 1;
    endfunction

    always @(negedge clk) begin
        logic [3:0] exp_v, act;
        int off, b;
        if (cyc >= 1) begin
            for (int i = 0; i < 2; i++) begin
                exp_v = expect_out(i, cyc - mdl_t0[i]);
                act   = dut_out[i];
                checks = checks + 1;
                if (act !== exp_v) begin
                    errors = errors + 1;
                    $display("FAIL cycle_cmp dut%0d cycle %0d: {tx,loading,busy,done} got %b want %b",
                             i, cyc, act, exp_v);
                end
                if (act[2] && !prev_ld[i]) push_ev(i, 1, cyc);
                if (!act[2] && prev_ld[i]) push_ev(i, 2, cyc);
                if (act[0]) push_ev(i, 3, cyc);
                prev_ld[i] = act[2];
                if (reset) begin
                    rx_on[i] = 1'b0;
                end else if (!rx_on[i]) begin
                    if (act[3] == 1'b0) begin
                        rx_on[i] = 1'b1;
                        rx_t0[i] = cyc;
                        rx_sh[i] = '0;
                        push_ev(i, 0, cyc);
                    end
                end else begin
                    off = cyc - rx_t0[i];
                    if (off % C == C / 2) begin
                        b = off / C;
                        if (b >= 1 && b <= 8) begin
                            rx_sh[i][b - 1] = act[3];
                        end else if (b == 9) begin
                            dec_buf[i][dec_n[i]] = rx_sh[i];
                            if (dec_n[i] < 2047) dec_n[i] = dec_n[i] + 1;
                            rx_on[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    function automatic int nth_ev(input int i, input int k, input int s, input int nth);
        int seen = 0;
        for (int e = 0; e < ev_n[i][k]; e++) begin
            if (ev_cyc[i][k][e] > s) begin
                if (seen == nth) return ev_cyc[i][k][e];
                seen++;
            end
        end
        return -1;
    endfunction

    function automatic int cnt_ev(input int i, input int k, input int s);
        int n = 0;
        for (int e = 0; e < ev_n[i][k]; e++) if (ev_cyc[i][k][e] > s) n++;
        return n;
    endfunction

    function automatic int dec_at(input int i, input int idx);
        return (idx < dec_n[i]) ? int'(dec_buf[i][idx]) : -1;
    endfunction

    // ---------------- stimulus ----------------
    task automatic chk(input string nm, input int act, input int exp_v);
        checks = checks + 1;
        if (act != exp_v) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d want %0d", nm, act, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input int i, input int a, input int d);
        wr_en[i] = 1'b1; wr_addr[i] = 9'(a); wr_data[i] = 8'(d);
        tick();
        wr_en[i] = 1'b0;
    endtask

    task automatic go(input int i, input int len, output int s);
        prog_len[i] = 10'(len); start[i] = 1'b1; s = cyc;
        tick();
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int i, input int s, input int budget);
        for (int n = 0; n < budget && cnt_ev(i, 3, s) == 0; n++) tick();
        tick();
        chk({nm, "_done_seen"}, (cnt_ev(i, 3, s) > 0) ? 1 : 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s, s2, base, bad;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_tx_a", int'(bus_a.tx), 1);
        chk("rst_loading_a", int'(bus_a.loading), 0);
        chk("rst_busy_a", int'(bus_a.busy), 0);
        chk("rst_done_a", int'(bus_a.done), 0);
        chk("rst_tx_b", int'(bus_b.tx), 1);

        // Two bytes; second write shares its cycle with start.
        wr(0, 0, 8'h2B);
        wr_en[0] = 1'b1; wr_addr[0] = 9'd1; wr_data[0] = 8'h2E;
        prog_len[0] = 10'd2; start[0] = 1'b1; s = cyc; base = dec_n[0];
        tick();
        wr_en[0] = 1'b0; start[0] = 1'b0;
        wait_done("t1", 0, s, 200);
        chk("t1_load_rise", nth_ev(0, 1, s, 0), s + 1);
        chk("t1_tx_fall", nth_ev(0, 0, s, 0), s + 3);
        chk("t1_frame1", nth_ev(0, 0, s, 1), s + 43);
        chk("t1_done", nth_ev(0, 3, s, 0), s + 83);
        chk("t1_load_fall", nth_ev(0, 2, s, 0), s + 83);
        chk("t1_done_cnt", cnt_ev(0, 3, s), 1);
        chk("t1_byte0", dec_at(0, base), 8'h2B);
        chk("t1_byte1", dec_at(0, base + 1), 8'h2E);

        // Zero-length request.
        go(0, 0, s);
        repeat (6) tick();
        chk("t2_load_rise", nth_ev(0, 1, s, 0), s + 1);
        chk("t2_load_fall", nth_ev(0, 2, s, 0), s + 2);
        chk("t2_done", nth_ev(0, 3, s, 0), s + 2);
        chk("t2_done_cnt", cnt_ev(0, 3, s), 1);
        chk("t2_no_frames", cnt_ev(0, 0, s), 0);
        chk("t2_busy_after", int'(bus_a.busy), 0);

        // start and writes during a transfer are ignored.
        base = dec_n[0];
        go(0, 2, s);
        for (int n = 0; n < 3; n++) begin
            repeat (9) tick();
            start[0] = 1'b1; wr_en[0] = 1'b1; wr_addr[0] = 9'd1; wr_data[0] = 8'hAA;
            tick();
            start[0] = 1'b0; wr_en[0] = 1'b0;
        end
        wait_done("t3", 0, s, 200);
        chk("t3_done", nth_ev(0, 3, s, 0), s + 83);
        chk("t3_done_cnt", cnt_ev(0, 3, s), 1);
        chk("t3_byte0", dec_at(0, base), 8'h2B);
        chk("t3_byte1", dec_at(0, base + 1), 8'h2E);
        base = dec_n[0];
        go(0, 2, s2);
        wait_done("t3r", 0, s2, 200);
        chk("t3r_byte1", dec_at(0, base + 1), 8'h2E);

        // Inter-frame gap of 3 cycles.
        wr(1, 0, 8'h00); wr(1, 1, 8'hFF); wr(1, 2, 8'h5A);
        base = dec_n[1];
        go(1, 3, s);
        wait_done("t4", 1, s, 400);
        chk("t4_frame0", nth_ev(1, 0, s, 0), s + 3);
        chk("t4_frame1", nth_ev(1, 0, s, 1), s + 46);
        chk("t4_frame2", nth_ev(1, 0, s, 2), s + 89);
        chk("t4_done", nth_ev(1, 3, s, 0), s + 132);
        chk("t4_byte0", dec_at(1, base), 8'h00);
        chk("t4_byte1", dec_at(1, base + 1), 8'hFF);
        chk("t4_byte2", dec_at(1, base + 2), 8'h5A);

        // Oversized length clamps to the 4-byte buffer.
        wr(1, 3, 8'h11);
        base = dec_n[1];
        go(1, 7, s);
        wait_done("tsat", 1, s, 400);
        chk("tsat_done", nth_ev(1, 3, s, 0), s + 175);
        chk("tsat_frames", cnt_ev(1, 0, s), 4);
        chk("tsat_byte3", dec_at(1, base + 3), 8'h11);

        // Reset in the middle of byte 1's data bits.
        go(0, 2, s);
        while (cyc < s + 55) tick();
        reset = 1'b1;
        tick();
        chk("t5_tx", int'(bus_a.tx), 1);
        chk("t5_loading", int'(bus_a.loading), 0);
        chk("t5_busy", int'(bus_a.busy), 0);
        reset = 1'b0;
        repeat (100) tick();
        chk("t5_no_done", cnt_ev(0, 3, s), 0);
        base = dec_n[0];
        go(0, 2, s2);
        wait_done("t5r", 0, s2, 200);
        chk("t5r_byte0", dec_at(0, base), 8'h2B);
        chk("t5r_byte1", dec_at(0, base + 1), 8'h2E);

        // Full 512-byte buffer, ramp 0..255 twice.
        for (int a = 0; a < 512; a++) wr(0, a, a % 256);
        base = dec_n[0];
        go(0, 512, s);
        wait_done("t6", 0, s, 21000);
        chk("t6_done", nth_ev(0, 3, s, 0), s + 3 + 512 * 40);
        chk("t6_frames", cnt_ev(0, 0, s), 512);
        bad = 0;
        for (int a = 0; a < 512; a++) if (dec_at(0, base + a) != a % 256) bad++;
        chk("t6_bad_bytes", bad, 0);

        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
